// File: rtl/mult_sequencer_if.sv
// mult_sequencer_if -- command, result and shared-ALU signals of mult_sequencer.
//
//   start         request to begin an unsigned 32x32 multiply
//   multiplicand  operand A, taken when start is accepted
//   multiplier    operand B, taken when start is accepted
//   busy          high while the sequencer iterates
//   done          one-cycle pulse, product valid
//   product_hi    upper 32 bits of the 64-bit product
//   product_lo    lower 32 bits of the 64-bit product
//   alu_src1      operand 1 to the shared 32-bit ALU
//   alu_src2      operand 2 to the shared 32-bit ALU
//   alu_ctr       ALU operation select
//   alu_result    combinational ALU result for the current alu_* request
//
// master: the environment (command issuer plus the shared ALU)
// slave:  the sequencer itself
interface mult_sequencer_if;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        done;
  logic [31:0] product_hi;
  logic [31:0] product_lo;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [2:0]  alu_ctr;
  logic [31:0] alu_result;

  modport master (
    output start, multiplicand, multiplier, alu_result,
    input  busy, done, product_hi, product_lo, alu_src1, alu_src2, alu_ctr
  );

  modport slave (
    input  start, multiplicand, multiplier, alu_result,
    output busy, done, product_hi, product_lo, alu_src1, alu_src2, alu_ctr
  );
endinterface

// File: rtl/mult_sequencer.sv
// mult_sequencer -- unsigned 32x32 shift-add multiplier that borrows an
// external 32-bit ALU for its additions, one iteration per clock.
//
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    mult_sequencer_if.slave: start/operands in, busy/done/product out,
//          alu_src1/alu_src2/alu_ctr out to the shared ALU, alu_result back
//
// Timing: start accepted at edge N -> busy for cycles N+1..N+32,
// done pulse in cycle N+33, product held until the next accepted start.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for start; product registers hold the last result
// S_RUN  | 32 add/shift iterations through the shared ALU
// S_DONE | one-cycle done pulse; start is ignored here
module mult_sequencer #(
  parameter logic [2:0] ADD_CODE  = 3'b101,
  parameter logic [2:0] IDLE_CODE = 3'b000
) (
  input  logic            clk,
  input  logic            rst_n,
  mult_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mcand;
  logic [4:0]  cnt;
  logic        carry;
  logic        last_iter;

  // The ALU is only 32 bits wide; an unsigned sum that wrapped is smaller
  // than the addend HI, which recovers bit 32 of the partial sum.
  assign carry     = (bus.alu_result < hi);
  assign last_iter = (cnt == 5'd31);

  assign bus.product_hi = hi;
  assign bus.product_lo = lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.alu_ctr  = IDLE_CODE;
    bus.alu_src1 = 32'h0;
    bus.alu_src2 = 32'h0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        bus.busy     = 1'b1;
        bus.alu_ctr  = ADD_CODE;
        bus.alu_src1 = hi;
        bus.alu_src2 = lo[0] ? mcand : 32'h0;
        if (last_iter) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        bus.done  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi    <= 32'h0;
      lo    <= 32'h0;
      mcand <= 32'h0;
      cnt   <= 5'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            mcand <= bus.multiplicand;
            lo    <= bus.multiplier;
            hi    <= 32'h0;
            cnt   <= 5'd0;
          end
        end
        S_RUN: begin
          // 33-bit partial sum {carry, alu_result} shifts right by one;
          // its low bit moves into the top of LO as the multiplier drains.
          hi  <= {carry, bus.alu_result[31:1]};
          lo  <= {bus.alu_result[0], lo[31:1]};
          cnt <= cnt + 5'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
